adc_div_seq: RTL

- Multi-cycle unsigned restoring divider controller. It sequences the shared 32-bit ADC subtractor (33-bit result A−B, bit 32 set iff A<B unsigned) through one trial subtraction per clock.
- Sits beside the ALU in the MIPS datapath and serves DIVU; HI/LO capture is done by the caller on `done`.
- The block owns no arithmetic of its own beyond shifts and the iteration counter. All subtraction goes through the external adder port.

---
 rtl/adc_div_seq.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/adc_div_seq.sv
// adc_div_seq: multi-cycle unsigned restoring divider controller.
// Drives the shared WIDTH-bit ADC subtractor with one trial subtraction per
// clock and owns only shifts and an iteration counter.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         request, sampled only while idle
//   dividend      numerator, captured on accept
//   divisor       denominator, captured on accept
//   busy          high while calculating and in the completion cycle
//   done          one-cycle completion pulse
//   quotient      result, held until the next accept
//   remainder     result, held until the next accept
//   div_by_zero   set with done when divisor was zero, held until next accept
//   add_a, add_b  minuend/subtrahend to the shared ADC (zero when not busy calculating)
//   add_s         ADC result add_a - add_b; bit WIDTH set iff add_a < add_b

module adc_div_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH:0]   add_s
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] add_a_q;
    logic [WIDTH-1:0] add_b_q;     // also serves as the captured divisor
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;

    // One restoring-division step, evaluated from the registered partial remainder.
    logic [WIDTH-1:0] p_c;
    logic             ok_c;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        p_c  = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
        // If R's MSB is set the shifted remainder has WIDTH+1 bits and is
        // certainly >= D; the truncated difference is still exact.
        ok_c = r_q[WIDTH-1] | ~add_s[WIDTH];
        r_d  = ok_c ? add_s[WIDTH-1:0] : p_c;
        q_d  = {q_q[WIDTH-2:0], ok_c};
    end

    // Controller state, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            add_a_q <= '0;
            add_b_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        q_q    <= dividend;
                        r_q    <= '0;
                        busy_q <= 1'b1;
                        if (divisor == '0) begin
                            // Adder port stays at zero on this path.
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            quot_q  <= '1;
                            rem_q   <= dividend;
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= S_CALC;
                            cnt_q   <= '0;
                            dbz_q   <= 1'b0;
                            // First trial operand: R=0 shifted with dividend MSB.
                            add_a_q <= WIDTH'(dividend[WIDTH-1]);
                            add_b_q <= divisor;
                        end
                    end
                end

                S_CALC: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        quot_q  <= q_d;
                        rem_q   <= r_d;
                        add_a_q <= '0;
                        add_b_q <= '0;
                    end else begin
                        // Present next iteration's shifted remainder to the ADC.
                        add_a_q <= {r_d[WIDTH-2:0], q_d[WIDTH-1]};
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    add_a_q <= '0;
                    add_b_q <= '0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign add_a       = add_a_q;
    assign add_b       = add_b_q;

endmodule
